// File: rtl/cfg_write_arbiter_if.sv
// Write-request bundle for cfg_write_arbiter: two requesters, each with valid/addr/data
// and a one-cycle ready acknowledge returned by the arbiter.
interface cfg_write_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  // Handshake: a requester raises valid with stable addr/data and holds it until it samples
  // ready high on a rising edge; ready is a single-cycle pulse and the write commits two edges later.
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Two-requester write arbiter owning the PWM/output configuration register bank.
// Optional build macro CFG_ARB_FIXED_PRIORITY_EN: requester 0 always wins ties (default round-robin).
module cfg_write_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cfg_write_arbiter_if.slave   req,
  output logic [DATA_W-1:0]    en_reg_out_7_0,
  output logic [DATA_W-1:0]    en_reg_out_15_8,
  output logic [DATA_W-1:0]    en_reg_pwm_7_0,
  output logic [DATA_W-1:0]    en_reg_pwm_15_8,
  output logic [DATA_W-1:0]    pwm_duty_cycle,
  output logic                 cfg_update,
  output logic                 wr_err,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] out_7_0_q, out_15_8_q, pwm_7_0_q, pwm_15_8_q, duty_q;
  logic              ready0_q, ready1_q, cfg_update_q, wr_err_q, busy_q;

  logic any_valid;
  logic grant1_d;
  logic addr_mapped;

  assign any_valid   = req.req0_valid | req.req1_valid;
  assign addr_mapped = (addr_q <= ADDR_W'(4));

`ifdef CFG_ARB_FIXED_PRIORITY_EN
  assign grant1_d = req.req1_valid & ~req.req0_valid;
`else
  logic last_grant_q;
  // last_grant_q = 1 means requester 1 won most recently, so requester 0 takes the next tie.
  assign grant1_d = req.req1_valid & (~req.req0_valid | ~last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ST_IDLE && any_valid) begin
      last_grant_q <= grant1_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      out_7_0_q    <= '0;
      out_15_8_q   <= '0;
      pwm_7_0_q    <= '0;
      pwm_15_8_q   <= '0;
      duty_q       <= '0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      cfg_update_q <= 1'b0;
      wr_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cfg_update_q <= 1'b0;
          wr_err_q     <= 1'b0;
          if (any_valid) begin
            addr_q   <= grant1_d ? req.req1_addr : req.req0_addr;
            data_q   <= grant1_d ? req.req1_data : req.req0_data;
            ready0_q <= ~grant1_d;
            ready1_q <= grant1_d;
            busy_q   <= 1'b1;
            state_q  <= ST_ACK;
          end
        end
        ST_ACK: begin
          ready0_q <= 1'b0;
          ready1_q <= 1'b0;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          // The held copy commits even if the winner dropped valid during ACK.
          case (addr_q)
            ADDR_W'(0): out_7_0_q  <= data_q;
            ADDR_W'(1): out_15_8_q <= data_q;
            ADDR_W'(2): pwm_7_0_q  <= data_q;
            ADDR_W'(3): pwm_15_8_q <= data_q;
            ADDR_W'(4): duty_q     <= data_q;
            default: ;
          endcase
          cfg_update_q <= addr_mapped;
          wr_err_q     <= ~addr_mapped;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          ready0_q <= 1'b0;
          ready1_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req.req0_ready  = ready0_q;
  assign req.req1_ready  = ready1_q;
  assign en_reg_out_7_0  = out_7_0_q;
  assign en_reg_out_15_8 = out_15_8_q;
  assign en_reg_pwm_7_0  = pwm_7_0_q;
  assign en_reg_pwm_15_8 = pwm_15_8_q;
  assign pwm_duty_cycle  = duty_q;
  assign cfg_update      = cfg_update_q;
  assign wr_err          = wr_err_q;
  assign busy            = busy_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_cfg_write_arbiter;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfg_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic              cfg_update, wr_err, busy;
  logic [1:0]        state_dbg;

  cfg_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (bus),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .cfg_update      (cfg_update),
    .wr_err          (wr_err),
    .busy            (busy),
    .state_dbg       (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction occupies three cycles from the sampling edge; m_left counts edges to commit.
  logic [DATA_W-1:0] m_regs [5];
  int                m_left;
  bit                m_last;
  bit                m_win;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                e_r0, e_r1, e_upd, e_err, e_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_left = 0; m_last = 1'b1;
      e_r0 = 0; e_r1 = 0; e_upd = 0; e_err = 0; e_busy = 0;
    end else begin
      e_r0 = 0; e_r1 = 0; e_upd = 0; e_err = 0;
      if (m_left == 0) begin
        if (bus.req0_valid || bus.req1_valid) begin
          if (!bus.req1_valid) m_win = 1'b0;
          else if (!bus.req0_valid) m_win = 1'b1;
          else begin
`ifdef CFG_ARB_FIXED_PRIORITY_EN
            m_win = 1'b0;
`else
            m_win = !m_last;
`endif
          end
          m_last = m_win;
          m_addr = m_win ? bus.req1_addr : bus.req0_addr;
          m_data = m_win ? bus.req1_data : bus.req0_data;
          if (m_win) e_r1 = 1; else e_r0 = 1;
          e_busy = 1;
          m_left = 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          e_busy = 0;
          if (m_addr < 5) begin
            m_regs[int'(m_addr)] = m_data;
            e_upd = 1;
          end else begin
            e_err = 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int upd_cnt = 0, err_cnt = 0, cyc = 0;
  int grant_q[$];
  int grant_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("req0_ready", bus.req0_ready, e_r0);
      check("req1_ready", bus.req1_ready, e_r1);
      check("cfg_update", cfg_update, e_upd);
      check("wr_err", wr_err, e_err);
      check("busy", busy, e_busy);
      check("en_reg_out_7_0", en_reg_out_7_0, m_regs[0]);
      check("en_reg_out_15_8", en_reg_out_15_8, m_regs[1]);
      check("en_reg_pwm_7_0", en_reg_pwm_7_0, m_regs[2]);
      check("en_reg_pwm_15_8", en_reg_pwm_15_8, m_regs[3]);
      check("pwm_duty_cycle", pwm_duty_cycle, m_regs[4]);
      if (cfg_update) upd_cnt++;
      if (wr_err) err_cnt++;
      if (bus.req0_ready) begin grant_q.push_back(0); grant_cyc.push_back(cyc); end
      if (bus.req1_ready) begin grant_q.push_back(1); grant_cyc.push_back(cyc); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int who, input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (who == 0) begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
    end
  endtask

  task automatic wait_ready(input int who, input int budget, output int lat);
    lat = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      lat++;
      if ((who == 0 && bus.req0_ready) || (who == 1 && bus.req1_ready)) return;
    end
    vectors++; miscompares++;
    $display("FAIL ready_timeout: req%0d got no ready within %0d cycles, want ready", who, budget);
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  int lat, u0, e0;
  int exp_g [3];

  initial begin
    set_req(0, 0, '0, '0);
    set_req(1, 0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset values
    check("rst en_reg_out_7_0", en_reg_out_7_0, 8'h00);
    check("rst en_reg_out_15_8", en_reg_out_15_8, 8'h00);
    check("rst en_reg_pwm_7_0", en_reg_pwm_7_0, 8'h00);
    check("rst en_reg_pwm_15_8", en_reg_pwm_15_8, 8'h00);
    check("rst pwm_duty_cycle", pwm_duty_cycle, 8'h00);
    check("rst ready0", bus.req0_ready, 1'b0);
    check("rst ready1", bus.req1_ready, 1'b0);
    check("rst cfg_update", cfg_update, 1'b0);
    check("rst wr_err", wr_err, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst state", state_dbg, 2'd0);

    // Single write: req0 0x04 <- 0x80
    u0 = upd_cnt;
    set_req(0, 1, 7'h04, 8'h80);
    wait_ready(0, 10, lat);
    check("single ready latency", lat, 1);
    @(negedge clk); set_req(0, 0, '0, '0);
    settle(3);
    check("single pwm_duty_cycle", pwm_duty_cycle, 8'h80);
    check("single cfg_update count", upd_cnt - u0, 1);

    // Contention from a fresh reset so the first tie goes to req0
    reset_dut();
    grant_q.delete(); grant_cyc.delete();
`ifdef CFG_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 0};
`else
    exp_g = '{0, 1, 0};
`endif
    @(negedge clk);
    set_req(0, 1, 7'h02, 8'h11);
    set_req(1, 1, 7'h03, 8'h22);
    for (int i = 0; i < 30 && grant_q.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    set_req(0, 0, '0, '0);
    set_req(1, 0, '0, '0);
    check("contend grant count", grant_q.size() >= 3, 1);
    if (grant_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("contend grant%0d", i), grant_q[i], exp_g[i]);
      check("contend spacing01", grant_cyc[1] - grant_cyc[0], 3);
      check("contend spacing12", grant_cyc[2] - grant_cyc[1], 3);
    end
    settle(4);
    check("contend en_reg_pwm_7_0", en_reg_pwm_7_0, 8'h11);
`ifdef CFG_ARB_FIXED_PRIORITY_EN
    check("contend en_reg_pwm_15_8", en_reg_pwm_15_8, 8'h00);
`else
    check("contend en_reg_pwm_15_8", en_reg_pwm_15_8, 8'h22);
`endif

    // Unmapped write: req1 0x05 <- 0xFF
    u0 = upd_cnt; e0 = err_cnt;
    set_req(1, 1, 7'h05, 8'hFF);
    wait_ready(1, 10, lat);
    check("err ready latency", lat, 1);
    @(negedge clk); set_req(1, 0, '0, '0);
    settle(3);
    check("err wr_err count", err_cnt - e0, 1);
    check("err cfg_update count", upd_cnt - u0, 0);
    check("err en_reg_out_7_0", en_reg_out_7_0, 8'h00);
    check("err en_reg_out_15_8", en_reg_out_15_8, 8'h00);
    check("err en_reg_pwm_7_0", en_reg_pwm_7_0, 8'h11);
    check("err pwm_duty_cycle", pwm_duty_cycle, 8'h00);

    // Winner drops valid during ACK: write still commits
    u0 = upd_cnt;
    set_req(0, 1, 7'h01, 8'h3C);
    wait_ready(0, 10, lat);
    set_req(0, 0, '0, '0);
    settle(3);
    check("drop en_reg_out_15_8", en_reg_out_15_8, 8'h3C);
    check("drop cfg_update count", upd_cnt - u0, 1);

    // Reset asserted during ACK abandons the write
    u0 = upd_cnt; e0 = err_cnt;
    set_req(0, 1, 7'h00, 8'h5A);
    wait_ready(0, 10, lat);
    rst = 1'b1;
    set_req(0, 0, '0, '0);
    @(negedge clk); rst = 1'b0;
    settle(3);
    check("rstack en_reg_out_7_0", en_reg_out_7_0, 8'h00);
    check("rstack cfg_update count", upd_cnt - u0, 0);
    check("rstack wr_err count", err_cnt - e0, 0);
    check("rstack busy", busy, 1'b0);
    check("rstack state", state_dbg, 2'd0);

    settle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, want bench completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
